// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Payload fields are sized for the widest XLEN; narrower builds use the low bits.
package imm_gen_pkg;

  localparam int unsigned XLEN_MAX = 64;
  localparam int unsigned FMT_W    = 3;
  localparam int unsigned OPC_W    = 7;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_e;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_e            fmt;
    logic                illegal;
    logic [XLEN_MAX-1:0] target;
  } imm_entry_t;

  // funct3 values of OP-IMM that encode shifts (SLLI / SRLI / SRAI)
  function automatic logic is_shift_funct3(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate expansion: decodes the opcode into a format tag,
// an XLEN-wide immediate and an illegal flag for unrecognised opcodes.
module imm_expand
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          SHAMT_ZEXT = 1'b1
) (
  input  logic [31:0]      inst_i,
  output logic [XLEN-1:0]  imm_c,
  output logic [2:0]       fmt_c,
  output logic             illegal_c
);

  logic [OPC_W-1:0] opcode;
  logic             sgn;
  logic [31:0]      raw32;
  logic [5:0]       shamt;

  assign opcode = inst_i[6:0];
  assign sgn    = inst_i[31];
  // RV64 shifts carry a 6-bit shamt, RV32 only 5
  assign shamt  = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};

  always_comb begin
    raw32     = '0;
    fmt_c     = FMT_NONE;
    illegal_c = 1'b0;
    imm_c     = '0;

    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        raw32 = {{20{sgn}}, inst_i[31:20]};
        fmt_c = FMT_I;
      end
      OPC_OPIMM: begin
        if (SHAMT_ZEXT && is_shift_funct3(inst_i[14:12])) begin
          fmt_c = FMT_SH;
        end else begin
          raw32 = {{20{sgn}}, inst_i[31:20]};
          fmt_c = FMT_I;
        end
      end
      OPC_STORE: begin
        raw32 = {{20{sgn}}, inst_i[31:25], inst_i[11:7]};
        fmt_c = FMT_S;
      end
      OPC_BRANCH: begin
        raw32 = {{19{sgn}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        fmt_c = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        raw32 = {inst_i[31:12], 12'b0};
        fmt_c = FMT_U;
      end
      OPC_JAL: begin
        raw32 = {{11{sgn}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        fmt_c = FMT_J;
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase

    // every signed format is built as 32 bits, then sign-extended to XLEN
    if (fmt_c == FMT_SH) begin
      imm_c = XLEN'(shamt);
    end else begin
      imm_c = XLEN'($signed(raw32));
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake, 1-cycle latency,
// a two-entry skid (M = output register, S = skid) and synchronous flush.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          SHAMT_ZEXT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  skid_state_e state_q, state_d;
  imm_entry_t  m_q, m_d;
  imm_entry_t  s_q, s_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic [XLEN-1:0] imm_c;
  logic [2:0]      fmt_c;
  logic            illegal_c;
  logic [XLEN-1:0] target_c;
  imm_entry_t      entry_c;
  logic            accept;
  logic            fire;

  imm_expand #(
    .XLEN       (XLEN),
    .SHAMT_ZEXT (SHAMT_ZEXT)
  ) u_expand (
    .inst_i    (in_inst),
    .imm_c     (imm_c),
    .fmt_c     (fmt_c),
    .illegal_c (illegal_c)
  );

  // target wraps modulo 2^XLEN
  assign target_c = in_pc + imm_c;

  always_comb begin
    entry_c         = '0;
    entry_c.imm     = XLEN_MAX'(imm_c);
    entry_c.fmt     = imm_fmt_e'(fmt_c);
    entry_c.illegal = illegal_c;
    entry_c.target  = XLEN_MAX'(target_c);
  end

  // a flushed cycle drops the incoming entry; an output fire still counts
  assign accept = in_valid && in_ready_q && !flush;
  assign fire   = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    s_d         = s_q;
    out_valid_d = 1'b0;
    in_ready_d  = 1'b1;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          m_d     = entry_c;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          m_d = entry_c;
        end else if (accept) begin
          s_d     = entry_c;
          state_d = ST_FULL;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only promotion can happen
        if (fire) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = m_q.imm[XLEN-1:0];
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;
  assign out_target  = m_q.target[XLEN-1:0];

  // upper payload bits stay zero when XLEN is narrower than the struct
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{m_q.imm[XLEN_MAX-1:XLEN], m_q.target[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vector table, skid/flush/reset sequences,
// and a randomized run against an arithmetic queue model (XLEN=32 and XLEN=64).
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHAMT_ZEXT(1'b1)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_pc(pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_target(tgt32)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_ZEXT(1'b0)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_target(tgt64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sext(input longint unsigned raw, input int w);
    if (((raw >> (w - 1)) & 64'd1) != 64'd0) return longint'(raw) - (longint'(1) <<< w);
    return longint'(raw);
  endfunction

  // Reference: immediate value as a signed integer, then reduced modulo 2^xlen
  function automatic imm_entry_t model(input logic [31:0] inst, input logic [63:0] pc,
                                       input int xlen, input bit zext);
    imm_entry_t        e;
    longint            v;
    longint unsigned   mask;
    logic [2:0]        f3;
    e    = '0;
    v    = 0;
    f3   = inst[14:12];
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (inst[6:0])
      7'b0000011, 7'b1100111: begin v = sext(64'(inst[31:20]), 12); e.fmt = FMT_I; end
      7'b0010011: begin
        if (zext && (f3 == 3'd1 || f3 == 3'd5)) begin
          v = (xlen == 64) ? longint'(64'(inst[25:20])) : longint'(64'(inst[24:20]));
          e.fmt = FMT_SH;
        end else begin
          v = sext(64'(inst[31:20]), 12); e.fmt = FMT_I;
        end
      end
      7'b0100011: begin v = sext((64'(inst[31:25]) << 5) | 64'(inst[11:7]), 12); e.fmt = FMT_S; end
      7'b1100011: begin
        v = sext((64'(inst[31]) << 12) | (64'(inst[7]) << 11) | (64'(inst[30:25]) << 5)
                 | (64'(inst[11:8]) << 1), 13);
        e.fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin v = sext(64'(inst[31:12]) << 12, 32); e.fmt = FMT_U; end
      7'b1101111: begin
        v = sext((64'(inst[31]) << 20) | (64'(inst[19:12]) << 12) | (64'(inst[20]) << 11)
                 | (64'(inst[30:21]) << 1), 21);
        e.fmt = FMT_J;
      end
      default: begin e.fmt = FMT_NONE; e.illegal = 1'b1; end
    endcase
    e.imm    = 64'(v) & mask;
    e.target = (pc + 64'(v)) & mask;
    return e;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tgt;
  } vec_t;

  vec_t        vecs [12];
  logic [6:0]  opc_pool [10];
  imm_entry_t  q32 [$];
  imm_entry_t  q64 [$];

  // one transaction from idle; on return the entry is on out_* and fires next edge
  task automatic send_one(input logic [31:0] inst, input logic [31:0] p32, input logic [63:0] p64);
    in_valid  = 1'b1;
    in_inst   = inst;
    pc32      = p32;
    pc64      = p64;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    imm_entry_t e64;
    logic [31:0] tmp;
    bit fire, acc;

    vecs[0]  = '{32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 3'd1, 1'b0, 32'hFFFF_FFFF};
    vecs[1]  = '{32'h123450B7, 32'h0000_0000, 32'h1234_5000, 3'd4, 1'b0, 32'h1234_5000};
    vecs[2]  = '{32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, 3'd3, 1'b0, 32'h0000_00FC};
    vecs[3]  = '{32'h0000006F, 32'h0000_0200, 32'h0000_0000, 3'd5, 1'b0, 32'h0000_0200};
    vecs[4]  = '{32'h4030D093, 32'h0000_1000, 32'h0000_0003, 3'd6, 1'b0, 32'h0000_1003};
    vecs[5]  = '{32'h0000007F, 32'h0000_0044, 32'h0000_0000, 3'd0, 1'b1, 32'h0000_0044};
    vecs[6]  = '{32'hFE112E23, 32'h0000_0010, 32'hFFFF_FFFC, 3'd2, 1'b0, 32'h0000_000C};
    vecs[7]  = '{32'h00412083, 32'h0000_0020, 32'h0000_0004, 3'd1, 1'b0, 32'h0000_0024};
    vecs[8]  = '{32'hFFFFF097, 32'h0000_3000, 32'hFFFF_F000, 3'd4, 1'b0, 32'h0000_2000};
    vecs[9]  = '{32'h7FF08067, 32'hFFFF_FFF0, 32'h0000_07FF, 3'd1, 1'b0, 32'h0000_07EF};
    vecs[10] = '{32'h00509093, 32'h0000_0000, 32'h0000_0005, 3'd6, 1'b0, 32'h0000_0005};
    vecs[11] = '{32'hFFDFF06F, 32'h0000_0040, 32'hFFFF_FFFC, 3'd5, 1'b0, 32'h0000_003C};
    opc_pool = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13, 7'h7F};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; pc32 = '0; pc64 = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_out_valid", 64'(out_valid32), 64'd0);
    check("reset_in_ready", 64'(in_ready32), 64'd1);
    check("reset_imm", 64'(imm32), 64'd0);
    check("reset_target", 64'(tgt32), 64'd0);
    reset = 1'b0;
    idle_cycle();

    // directed vectors
    for (int i = 0; i < 12; i++) begin
      send_one(vecs[i].inst, vecs[i].pc, {32'h0000_0001, vecs[i].pc});
      e64 = model(vecs[i].inst, {32'h0000_0001, vecs[i].pc}, 64, 1'b0);
      check($sformatf("vec%0d_valid", i), 64'(out_valid32), 64'd1);
      check($sformatf("vec%0d_imm", i), 64'(imm32), 64'(vecs[i].imm));
      check($sformatf("vec%0d_fmt", i), 64'(fmt32), 64'(vecs[i].fmt));
      check($sformatf("vec%0d_ill", i), 64'(ill32), 64'(vecs[i].ill));
      check($sformatf("vec%0d_tgt", i), 64'(tgt32), 64'(vecs[i].tgt));
      check($sformatf("vec%0d_imm64", i), imm64, e64.imm);
      check($sformatf("vec%0d_fmt64", i), 64'(fmt64), 64'(e64.fmt));
      check($sformatf("vec%0d_tgt64", i), tgt64, e64.target);
    end

    send_one(32'h800000B7, 32'h0, 64'h0);
    check("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    check("lui64_fmt", 64'(fmt64), 64'd4);
    send_one(32'h4030D093, 32'h0, 64'h0);
    check("srai_noz_imm", imm64, 64'h403);
    check("srai_noz_fmt", 64'(fmt64), 64'd1);
    check("srai_z_imm", 64'(imm32), 64'd3);
    idle_cycle();
    idle_cycle();

    // A,B,C back-to-back while the consumer stalls
    out_ready = 1'b0; in_valid = 1'b1; pc32 = 0; pc64 = 0;
    in_inst = 32'h00100093; @(posedge clk); #1;
    in_inst = 32'h00200093; @(posedge clk); #1;
    check("skid_full_in_ready", 64'(in_ready32), 64'd0);
    in_inst = 32'h00300093; @(posedge clk); #1;
    check("skid_hold_valid", 64'(out_valid32), 64'd1);
    check("skid_hold_a", 64'(imm32), 64'd1);
    check("skid_hold_in_ready", 64'(in_ready32), 64'd0);
    out_ready = 1'b1; @(posedge clk); #1;
    check("skid_drain_b", 64'(imm32), 64'd2);
    check("skid_drain_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("skid_drain_c", 64'(imm32), 64'd3);
    check("skid_drain_c_valid", 64'(out_valid32), 64'd1);
    @(posedge clk); #1;
    check("skid_empty", 64'(out_valid32), 64'd0);

    // flush while FULL with a same-cycle input
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00100093; @(posedge clk); #1;
    in_inst = 32'h00200093; @(posedge clk); #1;
    check("flush_pre_full", 64'(in_ready32), 64'd0);
    flush = 1'b1; in_inst = 32'h00300093; @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid32), 64'd0);
    check("flush_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk); #1;
    check("flush_dropped", 64'(out_valid32), 64'd0);

    // reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093; pc32 = 32'h1234; pc64 = 64'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_valid", 64'(out_valid32), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready32), 64'd1);
    check("rst_mid_imm", 64'(imm32), 64'd0);
    check("rst_mid_tgt", 64'(tgt32), 64'd0);
    check("rst_mid_imm64", imm64, 64'd0);
    @(posedge clk); #1;
    check("rst_mid_stay_empty", 64'(out_valid32), 64'd0);

    // randomized traffic against the queue model
    q32.delete(); q64.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("rnd_out_valid", 64'(out_valid32), 64'(q32.size() > 0));
      check("rnd_in_ready", 64'(in_ready32), 64'(q32.size() < 2));
      check("rnd_out_valid64", 64'(out_valid64), 64'(q64.size() > 0));
      if (q32.size() > 0) begin
        check("rnd_imm", 64'(imm32), q32[0].imm);
        check("rnd_fmt", 64'(fmt32), 64'(q32[0].fmt));
        check("rnd_ill", 64'(ill32), 64'(q32[0].illegal));
        check("rnd_tgt", 64'(tgt32), q32[0].target);
        check("rnd_imm64", imm64, q64[0].imm);
        check("rnd_tgt64", tgt64, q64[0].target);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tmp       = $urandom;
      tmp[6:0]  = opc_pool[int'($urandom_range(0, 9))];
      in_inst   = tmp;
      pc32      = $urandom;
      pc64      = {32'($urandom), 32'($urandom)};
      fire = (q32.size() > 0) && out_ready;
      acc  = in_valid && (q32.size() < 2) && !flush;
      if (fire) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (flush) begin
        q32.delete();
        q64.delete();
      end else if (acc) begin
        q32.push_back(model(in_inst, 64'(pc32), 32, 1'b1));
        q64.push_back(model(in_inst, pc64, 64, 1'b0));
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Sits between fetch and decode/execute. Accepts {inst, pc} over a valid/ready handshake and emits the expanded immediate, format tag, illegal flag and precomputed target pc+imm.
- 1-cycle latency, full throughput, 2-entry skid buffer for backpressure, synchronous flush for redirects.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHAMT_ZEXT, 1, 1: shift-immediates (OP-IMM funct3 001/101) yield zero-extended shamt only; 0: plain I-type sign extension.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  drop all buffered entries
- in_valid  input  1  input entry valid
- in_ready  output  1  block can accept an entry
- in_inst  input  32  instruction word
- in_pc  input  XLEN  pc of instruction
- out_valid  output  1  output entry valid
- out_ready  input  1  consumer accepts
- out_imm  output  XLEN  expanded immediate
- out_fmt  output  3  imm_fmt_e tag
- out_illegal  output  1  opcode not recognised
- out_target  output  XLEN  in_pc + out_imm, modulo 2^XLEN

Behaviour:
- Reset (synchronous, active-high): out_valid=0, skid entry invalid, in_ready=1 on the following cycle, all data registers 0. Reset has priority over flush and handshakes. Reset mid-stream discards everything.
- Accept occurs when in_valid && in_ready. Expansion is combinational on in_inst and is registered at accept.
- Entry appears on out_* the cycle after accept if the output is free.
- Opcode to format (sign bit inst[31], extended to XLEN):
  - 0000011, 1100111, 0010011: I, inst[31:20].
  - 0100011: S, {inst[31:25], inst[11:7]}.
  - 1100011: B, {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 0110111, 0010111: U, {inst[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - 1101111: J, {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 0010011 with funct3 001/101 and SHAMT_ZEXT=1: SH, zero-extended shamt. XLEN=32 uses inst[24:20]; XLEN=64 uses inst[25:20].
  - Any other opcode: imm=0, fmt=NONE, illegal=1. The entry still flows through the pipe; no stall, no drop.
- out_target = in_pc + imm, computed for every format and truncated to XLEN.
- Skid buffer, entries M (output register) and S (skid):
  - in_ready = !S.valid, driven from a register with no combinational path from out_ready.
  - Output fire (out_valid && out_ready) with accept: the new entry goes to M, or to S if S holds data (see promotion).
  - No output fire and M.valid with accept: entry goes to S.
  - Output fire with S.valid: S promotes to M, S clears.
  - Order is strictly FIFO. No loss, no duplication.
- States: EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
  - EMPTY to ONE on accept.
  - ONE stays ONE on accept plus fire, or on neither.
  - ONE to EMPTY on fire without accept.
  - ONE to FULL on accept without fire.
  - FULL to ONE on fire; accept is impossible in FULL.
- flush: next cycle M and S invalid (EMPTY) and in_ready=1. A same-cycle in_valid is dropped. A same-cycle output fire still counts as consumed.
- out_* data remain stable while out_valid && !out_ready.

Decomposition:
- Package imm_gen_pkg:
  - imm_fmt_e (3-bit): NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6.
  - Opcode localparams OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
  - Struct imm_entry_t {imm, fmt, illegal, target}.
- Sub-module imm_expand: purely combinational, parametrised by XLEN/SHAMT_ZEXT, producing imm/fmt/illegal. The top level holds the adder, skid buffer and handshake.

Test Plan:
- XLEN=32, after reset: ADDI 0xFFF00093, pc 0x0, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=I, illegal=0, target=0xFFFFFFFF.
- LUI 0x123450B7 -> imm=0x12345000, fmt=U. XLEN=64: LUI 0x800000B7 -> imm=0xFFFFFFFF80000000.
- BEQ 0xFE000EE3, pc 0x100 -> imm=0xFFFFFFFC, fmt=B, target=0x000000FC. JAL 0x0000006F -> imm=0, fmt=J.
- SRAI 0x4030D093: SHAMT_ZEXT=1 -> imm=3, fmt=SH; SHAMT_ZEXT=0 -> imm=0x403, fmt=I. Opcode 0x0000007F -> imm=0, fmt=NONE, illegal=1.
- Stream A,B,C back-to-back with out_ready=0 for 3 cycles -> A held on out_*, B in skid, in_ready=0, C held upstream. Then out_ready=1 -> A,B,C in consecutive cycles, in order.
- In FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped. Assert reset during streaming -> next cycle out_valid=0 and all data registers 0.
